// File: rtl/serial_tx_framer.sv
// serial_tx_framer: parallel-to-serial frame transmitter.
// Frame on SO: start bit (0), WIDTH data bits MSB first, optional even
// parity bit, STOP_BITS stop bits (1). Bit timing advances on TICK only.
// Optional feature macro: SER_PARITY_EN (compiles in the PARITY state).
module serial_tx_framer #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Handshake and status are decoded from the registered state.
  assign DIN_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign SO        = so_q;
  assign DONE      = done_q;

  // State register with asynchronous reset back to an idle, high line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      so_q       <= 1'b1;
      done_q     <= 1'b0;
`ifdef SER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      so_q       <= so_d;
      done_q     <= done_d;
`ifdef SER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state logic: SO is registered, so each branch sets the value
  // the line takes for the bit period that starts at this edge.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    so_d       = so_q;
    done_d     = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        so_d = 1'b1;
        // A TICK coinciding with the accept is deliberately ignored.
        if (DIN_VALID) begin
          state_d    = S_START;
          shreg_d    = DIN;
          stop_cnt_d = 1'b0;
          so_d       = 1'b0;
`ifdef SER_PARITY_EN
          par_d      = ^DIN;
`endif
        end
      end
      S_START: begin
        if (TICK) begin
          state_d   = S_DATA;
          so_d      = shreg_q[WIDTH-1];
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_idx_d = IDX_TOP;
        end
      end
      S_DATA: begin
        // bit_idx_q names the data bit currently on SO; stop at 0, no wrap.
        if (TICK) begin
          if (bit_idx_q == '0) begin
`ifdef SER_PARITY_EN
            state_d = S_PARITY;
            so_d    = par_q;
`else
            state_d    = S_STOP;
            so_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            so_d      = shreg_q[WIDTH-1];
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (TICK) begin
          state_d    = S_STOP;
          so_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        so_d = 1'b1;
        if (TICK) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        so_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: two instances (STOP_BITS=1 and 2, WIDTH=8).
// Expected frames are built from the frame rules as bit lists in queues;
// a negedge monitor compares SO/BUSY/DIN_READY/DONE against the queue head.
module tb_serial_tx_framer;

  logic       CLK;
  logic       RST;
  logic       tick [2];
  logic       vld  [2];
  logic [7:0] din  [2];
  logic       rdy  [2];
  logic       so   [2];
  logic       busy [2];
  logic       done [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc [2];
  int tick_per [2];
  int tcnt     [2];
  bit tick_rnd [2];

  // Expected line values per bit period; value 2 marks the DONE cycle.
  int q0[$];
  int q1[$];

  serial_tx_framer #(.WIDTH(8), .STOP_BITS(1)) u0 (
    .CLK(CLK), .RST(RST), .TICK(tick[0]), .DIN(din[0]), .DIN_VALID(vld[0]),
    .DIN_READY(rdy[0]), .SO(so[0]), .BUSY(busy[0]), .DONE(done[0]));

  serial_tx_framer #(.WIDTH(8), .STOP_BITS(2)) u1 (
    .CLK(CLK), .RST(RST), .TICK(tick[1]), .DIN(din[1]), .DIN_VALID(vld[1]),
    .DIN_READY(rdy[1]), .SO(so[1]), .BUSY(busy[1]), .DONE(done[1]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void qpush(int d, int v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction
  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic int qfront(int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void qpop(int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  // Reference frame: start, data MSB first, [even parity], stop bits, DONE.
  function automatic void push_frame(int d, logic [7:0] w);
    int stops = d + 1;
    qpush(d, 0);
    for (int i = 7; i >= 0; i--) qpush(d, w[i] ? 1 : 0);
`ifdef SER_PARITY_EN
    qpush(d, (^w) ? 1 : 0);
`endif
    for (int s = 0; s < stops; s++) qpush(d, 1);
    qpush(d, 2);
  endfunction

  // Monitor: compare every cycle against the head of the expected queue.
  task automatic mon_step(int d);
    int  f;
    bit  idle_exp;
    idle_exp = (qsize(d) == 0) || (qfront(d) == 2);
    chk("din_ready", int'(rdy[d]), idle_exp ? 1 : 0);
    chk("busy", int'(busy[d]), idle_exp ? 0 : 1);
    if (qsize(d) == 0) begin
      chk("idle_so", int'(so[d]), 1);
      chk("idle_done", int'(done[d]), 0);
    end else begin
      f = qfront(d);
      if (f == 2) begin
        chk("done_pulse", int'(done[d]), 1);
        chk("done_so", int'(so[d]), 1);
        done_cyc[d] = cyc;
        qpop(d);
      end else begin
        chk("frame_bit", int'(so[d]), f);
        chk("early_done", int'(done[d]), 0);
        if (tick[d]) qpop(d);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      for (int d = 0; d < 2; d++) mon_step(d);
    end
  end

  // TICK generator: fixed period or random, driven just after the edge.
  initial begin
    tick[0] = 1'b1;
    tick[1] = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (tick_rnd[d]) begin
          tick[d] = ($urandom_range(0, 1) == 1);
        end else begin
          tick[d] = (tcnt[d] == 0);
          tcnt[d] = (tcnt[d] + 1 >= tick_per[d]) ? 0 : tcnt[d] + 1;
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Offer a word; returns just after the accepting edge with DIN_VALID still high.
  task automatic send(int d, logic [7:0] w, output int acc_cyc);
    int n = 0;
    din[d] = w;
    vld[d] = 1'b1;
    while (!rdy[d] && n < 500) begin
      step(1);
      n++;
    end
    acc_cyc = cyc;
    if (n >= 500) begin
      chk("accept_timeout", 0, 1);
    end else begin
      step(1);
      push_frame(d, w);
    end
  endtask

  task automatic idle(int d);
    vld[d] = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int n = 0;
    while (qsize(d) != 0 && n < 1000) begin
      step(1);
      n++;
    end
    if (n >= 1000) chk("frame_timeout", qsize(d), 0);
  endtask

  task automatic rand_loop(int d);
    int a;
    for (int i = 0; i < 25; i++) begin
      send(d, 8'($urandom), a);
      if ($urandom_range(0, 2) != 0) begin
        idle(d);
        step($urandom_range(0, 6));
      end
    end
    idle(d);
    wait_idle(d);
  endtask

  initial begin
    int a0, a1;
    RST = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0;
      din[d] = 8'h00;
      tick_per[d] = 1;
      tcnt[d] = 0;
      tick_rnd[d] = 1'b0;
      done_cyc[d] = -1;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      chk("reset_so", int'(so[d]), 1);
      chk("reset_busy", int'(busy[d]), 0);
      chk("reset_ready", int'(rdy[d]), 1);
      chk("reset_done", int'(done[d]), 0);
    end
    step(2);
    RST = 1'b0;
    step(2);

    // 0xA5 with a bit period of 4 cycles.
    tick_per[0] = 4;
    send(0, 8'hA5, a0);
    idle(0);
    wait_idle(0);

    // TICK held high: one cycle per bit; 0x07 has odd weight.
    tick_per[0] = 1;
    send(0, 8'hA5, a0);
    idle(0);
    wait_idle(0);
    send(0, 8'h07, a0);
    idle(0);
    wait_idle(0);

    // Back-to-back: second accept must land in the DONE cycle.
    send(0, 8'h3C, a0);
    send(0, 8'hC3, a1);
    chk("b2b_accept_in_done_cycle", a1, done_cyc[0]);
    idle(0);
    wait_idle(0);

    // DIN_VALID while busy is ignored.
    send(0, 8'h5A, a0);
    idle(0);
    step(3);
    vld[0] = 1'b1;
    din[0] = 8'hFF;
    chk("busy_not_ready", int'(rdy[0]), 0);
    step(1);
    vld[0] = 1'b0;
    wait_idle(0);

    // Two stop bits, bit period of 2 cycles, all-zero data.
    tick_per[1] = 2;
    send(1, 8'h00, a0);
    idle(1);
    wait_idle(1);

    // Asynchronous reset in the middle of the data bits.
    tick_per[0] = 1;
    send(0, 8'($urandom), a0);
    idle(0);
    step(5);
    RST = 1'b1;
    #1;
    chk("midreset_so", int'(so[0]), 1);
    chk("midreset_busy", int'(busy[0]), 0);
    chk("midreset_ready", int'(rdy[0]), 1);
    chk("midreset_done", int'(done[0]), 0);
    q0.delete();
    q1.delete();
    step(1);
    RST = 1'b0;
    step(2);
    send(0, 8'h96, a0);
    idle(0);
    wait_idle(0);

    // Randomized traffic on both instances with random TICK.
    tick_rnd[0] = 1'b1;
    tick_rnd[1] = 1'b1;
    fork
      rand_loop(0);
      rand_loop(1);
    join
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
